// File: rtl/map_pixel_responder.sv
// Map pixel lookup server: accepts (col,row) probes, reads a fixed-latency map ROM and
// returns pixel code plus WALL/HOLE/WIN class in request order through a credit-guarded FIFO.
module map_pixel_responder #(
  parameter int         MAP_COLS    = 640,
  parameter int         MAP_ROWS    = 480,
  parameter int         ADDR_WIDTH  = 19,
  parameter int         ROM_LATENCY = 2,
  parameter logic [7:0] WALL        = 8'h26,
  parameter logic [7:0] HOLE        = 8'h49,
  parameter logic [7:0] WIN         = 8'hF9
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [9:0]            req_col_i,
  input  logic [9:0]            req_row_i,
  output logic                  rom_en_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [7:0]            rom_data_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [7:0]            rsp_pixel_o,
  output logic [1:0]            rsp_class_o,
  output logic                  rsp_oob_o
);

  localparam int         DEPTH   = ROM_LATENCY + 2;
  localparam int         CNT_W   = $clog2(DEPTH + 1);
  localparam int         PTR_W   = $clog2(DEPTH);
  localparam logic [10:0] COL_LIM = 11'(MAP_COLS);
  localparam logic [10:0] ROW_LIM = 11'(MAP_ROWS);

  logic                  accept;
  logic                  pop;
  logic                  reqOob;
  logic [ADDR_WIDTH-1:0] linAddr;

  logic                  req_ready_q;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic                  rom_en_q;
  logic [ADDR_WIDTH-1:0] rom_addr_q;
  logic [ROM_LATENCY:0]  tagValid_q;
  logic [ROM_LATENCY:0]  tagOob_q;

  logic                  wrEn;
  logic [7:0]            wrPixel;
  logic [1:0]            wrClass;

  logic [10:0]           fifoMem_q [DEPTH];
  logic [PTR_W-1:0]      wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0]      count_q, count_d;

  assign accept  = req_valid_i && req_ready_q;
  assign pop     = rsp_valid_o && rsp_ready_i;
  assign reqOob  = ({1'b0, req_col_i} >= COL_LIM) || ({1'b0, req_row_i} >= ROW_LIM);
  // Modular arithmetic makes the narrow product equal to the full-width result truncated.
  assign linAddr = ADDR_WIDTH'(req_row_i) * ADDR_WIDTH'(MAP_COLS) + ADDR_WIDTH'(req_col_i);

  // Tag index ROM_LATENCY lines up with rom_data for the probe accepted ROM_LATENCY+1 edges ago.
  assign wrEn    = tagValid_q[ROM_LATENCY];
  assign wrPixel = tagOob_q[ROM_LATENCY] ? WALL : rom_data_i;

  always_comb begin
    wrClass = 2'b00;
    if (wrPixel == WALL)     wrClass = 2'b01;
    else if (wrPixel == HOLE) wrClass = 2'b10;
    else if (wrPixel == WIN)  wrClass = 2'b11;
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept && !pop)      inflight_d = inflight_q + CNT_W'(1);
    else if (!accept && pop) inflight_d = inflight_q - CNT_W'(1);
  end

  always_comb begin
    count_d = count_q;
    if (wrEn && !pop)      count_d = count_q + CNT_W'(1);
    else if (!wrEn && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_ready_q <= 1'b0;
      inflight_q  <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      tagValid_q  <= '0;
      tagOob_q    <= '0;
    end else begin
      inflight_q  <= inflight_d;
      req_ready_q <= (inflight_d < CNT_W'(DEPTH));
      rom_en_q    <= accept && !reqOob;
      if (accept && !reqOob) rom_addr_q <= linAddr;
      tagValid_q  <= {tagValid_q[ROM_LATENCY-1:0], accept};
      tagOob_q    <= {tagOob_q[ROM_LATENCY-1:0], reqOob};
    end
  end

  // First-word-fall-through response FIFO; head entry drives the rsp_* outputs directly.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) fifoMem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      if (wrEn) begin
        fifoMem_q[wrPtr_q] <= {tagOob_q[ROM_LATENCY], wrClass, wrPixel};
        wrPtr_q <= (wrPtr_q == PTR_W'(DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
      end
      if (pop) rdPtr_q <= (rdPtr_q == PTR_W'(DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
    end
  end

  assign req_ready_o = req_ready_q;
  assign rom_en_o    = rom_en_q;
  assign rom_addr_o  = rom_addr_q;
  assign rsp_valid_o = (count_q != '0);
  assign {rsp_oob_o, rsp_class_o, rsp_pixel_o} = fifoMem_q[rdPtr_q];

  noOverflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                               !(wrEn && (count_q == CNT_W'(DEPTH))));

endmodule

// File: tb/tb_map_pixel_responder.sv
// Scoreboard bench for map_pixel_responder: a behavioural ROM model feeds the DUT and
// expected responses queued at accept time are compared when responses are popped.
module tb_map_pixel_responder;

  localparam int COLS = 640;
  localparam int ROWS = 480;
  localparam int AW   = 19;
  localparam int LAT  = 2;

  typedef struct {
    logic [7:0] pix;
    logic [1:0] cls;
    logic       oob;
    int         edgeNo;
  } expT;

  logic          clk = 1'b0;
  logic          rstN;
  logic          reqValid;
  logic          reqReady;
  logic [9:0]    reqCol;
  logic [9:0]    reqRow;
  logic          romEn;
  logic [AW-1:0] romAddr;
  logic [7:0]    romData;
  logic          rspValid;
  logic          rspReady;
  logic [7:0]    rspPixel;
  logic [1:0]    rspClass;
  logic          rspOob;

  int vectorCount = 0;
  int missCount   = 0;
  int edgeCount   = 0;
  int acceptCount = 0;
  bit checkLat    = 1'b1;
  bit holdArmed   = 1'b0;
  logic [7:0] heldPix;
  logic [1:0] heldCls;
  logic       heldOob;

  expT           expQ[$];
  logic [AW-1:0] addrQ[$];
  expT           monExp;
  expT           monGot;
  logic [AW-1:0] monAddr;

  logic [7:0] romPipe [LAT];

  always #5 clk = ~clk;

  map_pixel_responder dut (
    .clk_i       (clk),
    .rst_ni      (rstN),
    .req_valid_i (reqValid),
    .req_ready_o (reqReady),
    .req_col_i   (reqCol),
    .req_row_i   (reqRow),
    .rom_en_o    (romEn),
    .rom_addr_o  (romAddr),
    .rom_data_i  (romData),
    .rsp_valid_o (rspValid),
    .rsp_ready_i (rspReady),
    .rsp_pixel_o (rspPixel),
    .rsp_class_o (rspClass),
    .rsp_oob_o   (rspOob)
  );

  function automatic logic [7:0] romValue(input logic [AW-1:0] a);
    case (a)
      19'd1285: return 8'h10;
      19'd10:   return 8'h26;
      19'd11:   return 8'h49;
      19'd12:   return 8'hF9;
      19'd13:   return 8'h00;
      default:  return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [1:0] expClass(input logic [7:0] p);
    if (p == 8'h26) return 2'b01;
    if (p == 8'h49) return 2'b10;
    if (p == 8'hF9) return 2'b11;
    return 2'b00;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [9:0] c, input logic [9:0] r);
    reqValid = v;
    reqCol   = c;
    reqRow   = r;
  endtask

  task automatic sendProbe(input logic [9:0] c, input logic [9:0] r);
    bit ok = 1'b0;
    applyStimulus(1'b1, c, r);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (reqReady) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput("acceptTimeout", 32'd0, 32'd1);
    tick();
    reqValid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (expQ.size() == 0 && !rspValid) begin ok = 1'b1; break; end
    end
    if (!ok) checkOutput("drainTimeout", 32'(expQ.size()), 32'd0);
    tick();
  endtask

  // The behavioural ROM captures rom_en/rom_addr on the edge and returns data LAT edges later;
  // non-requested slots carry junk so stale data would be visible.
  always @(posedge clk) begin
    romPipe[0] <= romEn ? romValue(romAddr) : 8'($urandom);
    for (int i = 1; i < LAT; i++) romPipe[i] <= romPipe[i-1];
  end
  assign romData = romPipe[LAT-1];

  always @(posedge clk) edgeCount <= edgeCount + 1;

  // Monitor: accepts push expectations, ROM strobes and response pops are checked against them.
  always @(negedge clk) begin
    if (rstN) begin
      if (reqValid && reqReady) begin
        acceptCount++;
        monExp.oob    = (int'(reqCol) >= COLS) || (int'(reqRow) >= ROWS);
        monAddr       = AW'(int'(reqRow) * COLS + int'(reqCol));
        monExp.pix    = monExp.oob ? 8'h26 : romValue(monAddr);
        monExp.cls    = expClass(monExp.pix);
        monExp.edgeNo = edgeCount + 1;
        expQ.push_back(monExp);
        if (!monExp.oob) addrQ.push_back(monAddr);
      end
      if (romEn) begin
        if (addrQ.size() == 0) checkOutput("romEnSpurious", 32'd1, 32'd0);
        else checkOutput("romAddr", 32'(romAddr), 32'(addrQ.pop_front()));
      end
      if (holdArmed) begin
        checkOutput("holdValid", 32'(rspValid), 32'd1);
        checkOutput("holdPixel", 32'(rspPixel), 32'(heldPix));
        checkOutput("holdClass", 32'(rspClass), 32'(heldCls));
        checkOutput("holdOob",   32'(rspOob),   32'(heldOob));
      end
      holdArmed = rspValid && !rspReady;
      heldPix = rspPixel;
      heldCls = rspClass;
      heldOob = rspOob;
      if (rspValid && rspReady) begin
        if (expQ.size() == 0) checkOutput("rspSpurious", 32'd1, 32'd0);
        else begin
          monGot = expQ.pop_front();
          checkOutput("rspPixel", 32'(rspPixel), 32'(monGot.pix));
          checkOutput("rspClass", 32'(rspClass), 32'(monGot.cls));
          checkOutput("rspOob",   32'(rspOob),   32'(monGot.oob));
          if (checkLat) checkOutput("rspLatency", 32'(edgeCount), 32'(monGot.edgeNo + 3));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN     = 1'b0;
    rspReady = 1'b1;
    applyStimulus(1'b0, 10'd0, 10'd0);
    repeat (3) tick();

    @(negedge clk);
    checkOutput("rstRspValid", 32'(rspValid), 32'd0);
    checkOutput("rstRspPixel", 32'(rspPixel), 32'd0);
    checkOutput("rstRspClass", 32'(rspClass), 32'd0);
    checkOutput("rstRspOob",   32'(rspOob),   32'd0);
    checkOutput("rstRomEn",    32'(romEn),    32'd0);
    checkOutput("rstRomAddr",  32'(romAddr),  32'd0);
    checkOutput("rstReqReady", 32'(reqReady), 32'd0);
    tick();
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("relReadyLow", 32'(reqReady), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("relReadyHigh", 32'(reqReady), 32'd1);
    tick();

    $display("[TB] single probe");
    sendProbe(10'd5, 10'd2);
    drain();

    $display("[TB] back-to-back classes");
    sendProbe(10'd10, 10'd0);
    sendProbe(10'd11, 10'd0);
    sendProbe(10'd12, 10'd0);
    sendProbe(10'd13, 10'd0);
    drain();

    $display("[TB] bounds");
    sendProbe(10'd640, 10'd0);
    sendProbe(10'd0, 10'd480);
    sendProbe(10'd639, 10'd479);
    sendProbe(10'd1023, 10'd1023);
    drain();

    $display("[TB] back-pressure");
    checkLat    = 1'b0;
    acceptCount = 0;
    rspReady    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 10'(100 + k), 10'd7);
      tick();
    end
    reqValid = 1'b0;
    @(negedge clk);
    checkOutput("bpAccepts",  32'(acceptCount), 32'd4);
    checkOutput("bpReady",    32'(reqReady),    32'd0);
    checkOutput("bpRspValid", 32'(rspValid),    32'd1);
    tick();

    $display("[TB] full credits");
    applyStimulus(1'b1, 10'd200, 10'd9);
    rspReady = 1'b1;
    @(negedge clk);
    checkOutput("fullNoAccept", 32'(reqReady), 32'd0);
    tick();
    rspReady = 1'b0;
    @(negedge clk);
    checkOutput("fullReadyBack", 32'(reqReady), 32'd1);
    tick();
    reqValid = 1'b0;
    @(negedge clk);
    checkOutput("fullStay",    32'(reqReady),    32'd0);
    checkOutput("fullAccepts", 32'(acceptCount), 32'd5);
    tick();
    rspReady = 1'b1;
    drain();

    $display("[TB] reset mid-operation");
    checkLat = 1'b1;
    sendProbe(10'd1, 10'd1);
    sendProbe(10'd2, 10'd1);
    tick();
    rstN = 1'b0;
    expQ.delete();
    addrQ.delete();
    holdArmed = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rstMidValid", 32'(rspValid), 32'd0);
    end
    tick();
    rstN = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("rstPostValid", 32'(rspValid), 32'd0);
    end
    tick();
    sendProbe(10'd3, 10'd3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
